// File: rtl/cordic_angle_reduce.sv
// cordic_angle_reduce: range-reduction front end of the CORDIC datapath.
// Pops raw Q(32-IN_FRAC).IN_FRAC angles from a first-word-fall-through FIFO,
// folds them into [-pi/2, pi/2] and emits a Q2.14 angle plus a negate flag
// (downstream negates both cos and sin when set). Three register stages with
// a single global stall; one angle per cycle when unstalled.
module cordic_angle_reduce #(
  parameter int IN_FRAC  = 20,
  parameter int OUT_FRAC = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_empty,
  input  logic [31:0] in_dout,
  output logic        in_rd_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_theta,
  output logic        out_neg
);

  // pi scaled by 2^61, truncated; every constant below is rounded from it so
  // they all track IN_FRAC without hand-entered magic numbers.
  localparam logic [63:0] PI_Q61 = 64'h6487_ED51_10B4_611A;

  localparam logic [63:0] PI_U      = ((PI_Q61 >> (60 - IN_FRAC)) + 64'd1) >> 1;
  localparam logic [63:0] HALF_PI_U = ((PI_Q61 >> (61 - IN_FRAC)) + 64'd1) >> 1;

  localparam logic signed [32:0] K_PI      = PI_U[32:0];
  localparam logic signed [32:0] K_TWO_PI  = K_PI <<< 1;
  localparam logic signed [32:0] K_HALF_PI = HALF_PI_U[32:0];

  localparam int                 SH    = IN_FRAC - OUT_FRAC;
  localparam logic signed [32:0] K_RND = 33'sd1 <<< (SH - 1);
  localparam logic signed [32:0] Q_MAX = 33'sd32767;
  localparam logic signed [32:0] Q_MIN = -33'sd32768;

  // Pipeline state.
  logic                s1_valid;
  logic signed [32:0]  s1_theta;
  logic                s2_valid;
  logic signed [32:0]  s2_theta;
  logic                s2_neg;

  logic                advance;
  logic signed [32:0]  s1_in;
  logic signed [32:0]  s1_clamp;
  logic signed [32:0]  s1_wrap;
  logic signed [32:0]  s2_fold;
  logic                s2_fold_neg;
  logic signed [32:0]  s3_round;
  logic signed [32:0]  s3_shift;
  logic [15:0]         s3_sat;

  // Global stall: every stage moves together only when the output slot frees.
  assign advance  = !out_valid || out_ready;
  assign in_rd_en = reset && !in_empty && advance;

  // S1 combinational: clamp to +-2pi then wrap into [-pi, pi).
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    s1_in    = {in_dout[31], in_dout};
    s1_clamp = s1_in;
    s1_wrap  = '0;
    if (s1_in > K_TWO_PI)
      s1_clamp = K_TWO_PI;
    else if (s1_in < -K_TWO_PI)
      s1_clamp = -K_TWO_PI;

    s1_wrap = s1_clamp;
    if (s1_clamp >= K_PI)
      s1_wrap = s1_clamp - K_TWO_PI;
    else if (s1_clamp < -K_PI)
      s1_wrap = s1_clamp + K_TWO_PI;
  end

  // S2 combinational: fold the outer half-circle by pi and request negation.
  always_comb begin
    s2_fold     = s1_theta;
    s2_fold_neg = 1'b0;
    if (s1_theta > K_HALF_PI) begin
      s2_fold     = s1_theta - K_PI;
      s2_fold_neg = 1'b1;
    end else if (s1_theta < -K_HALF_PI) begin
      s2_fold     = s1_theta + K_PI;
      s2_fold_neg = 1'b1;
    end
  end

  // S3 combinational: round half up to OUT_FRAC bits and saturate to 16 bits.
  always_comb begin
    s3_round = s2_theta + K_RND;
    s3_shift = s3_round >>> SH;
    s3_sat   = s3_shift[15:0];
    if (s3_shift > Q_MAX)
      s3_sat = 16'h7FFF;
    else if (s3_shift < Q_MIN)
      s3_sat = 16'h8000;
  end

  // Stage registers: all advance together or all hold; reset flushes in-flight words.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: datapath registers are reset too, so out_theta/out_neg read 0 in reset.
    if (!reset) begin
      s1_valid  <= 1'b0;
      s1_theta  <= '0;
      s2_valid  <= 1'b0;
      s2_theta  <= '0;
      s2_neg    <= 1'b0;
      out_valid <= 1'b0;
      out_theta <= '0;
      out_neg   <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let each stage read the previous stage's old value.
      s1_valid  <= in_rd_en;
      s1_theta  <= s1_wrap;
      s2_valid  <= s1_valid;
      s2_theta  <= s2_fold;
      s2_neg    <= s2_fold_neg;
      out_valid <= s2_valid;
      out_theta <= s3_sat;
      out_neg   <= s2_neg;
    end
  end

endmodule
